// File: rtl/os_pkg.sv
// Shared ordered-set constants: symbol values, osType codes and LTSSM substate codes.
package os_pkg;

  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] SKP    = 8'h1C;
  localparam logic [7:0] IDL    = 8'h7C;
  localparam logic [7:0] EIE    = 8'hFC;
  localparam logic [7:0] PAD    = 8'hF7;
  localparam logic [7:0] TS1ID  = 8'h4A;
  localparam logic [7:0] TS2ID  = 8'h45;
  localparam logic [7:0] G3TS1  = 8'h1E;
  localparam logic [7:0] G3TS2  = 8'h2D;
  localparam logic [7:0] G3EIOS = 8'h66;
  localparam logic [7:0] G3SKP  = 8'hAA;

  localparam logic [2:0] OS_NONE  = 3'd0;
  localparam logic [2:0] OS_TS1   = 3'd1;
  localparam logic [2:0] OS_TS2   = 3'd2;
  localparam logic [2:0] OS_EIOS  = 3'd3;
  localparam logic [2:0] OS_EIEOS = 3'd4;
  localparam logic [2:0] OS_SKP   = 3'd5;

  localparam logic [4:0] SS_DETECT_QUIET      = 5'd0;
  localparam logic [4:0] SS_DETECT_ACTIVE     = 5'd1;
  localparam logic [4:0] SS_POLLING_ACTIVE    = 5'd2;
  localparam logic [4:0] SS_POLLING_CONFIG    = 5'd3;
  localparam logic [4:0] SS_CONFIG_LINKWIDTH  = 5'd4;
  localparam logic [4:0] SS_CONFIG_LANENUM    = 5'd5;
  localparam logic [4:0] SS_CONFIG_COMPLETE   = 5'd6;
  localparam logic [4:0] SS_CONFIG_IDLE       = 5'd7;
  localparam logic [4:0] SS_L0                = 5'd8;
  localparam logic [4:0] SS_RECOVERY_RCVRLOCK = 5'd9;
  localparam logic [4:0] SS_RECOVERY_RCVRCFG  = 5'd10;
  localparam logic [4:0] SS_RECOVERY_IDLE     = 5'd11;

  localparam int KEY_W = 43;

  function automatic logic is_ts(input logic [2:0] t);
    return (t == OS_TS1) || (t == OS_TS2);
  endfunction

endpackage

// File: rtl/os_lane_classifier.sv
// Classifies the 16-symbol ordered set held in one lane slot.
module os_lane_classifier
  import os_pkg::*;
(
  input  logic [2:0]   gen,
  input  logic [127:0] lane,
  output logic [2:0]   os_class
);

  logic [7:0] s [16];
  logic g1_ts1, g1_ts2, g1_eios, g1_skp, g1_eieos;
  logic g3_eios, g3_eieos, g3_skp;

  for (genvar k = 0; k < 16; k++) begin : g_sym
    assign s[k] = lane[8*k +: 8];
  end

  always_comb begin
    g1_ts1   = 1'b1;
    g1_ts2   = 1'b1;
    g1_eios  = 1'b1;
    g1_skp   = 1'b1;
    g1_eieos = 1'b1;
    g3_eios  = 1'b1;
    g3_eieos = 1'b1;
    g3_skp   = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k >= 6) begin
        g1_ts1 = g1_ts1 & (s[k] == TS1ID);
        g1_ts2 = g1_ts2 & (s[k] == TS2ID);
      end
      if (k >= 1 && k <= 3) begin
        g1_eios = g1_eios & (s[k] == IDL);
        g1_skp  = g1_skp & (s[k] == SKP);
      end
      if (k >= 1 && k <= 14) g1_eieos = g1_eieos & (s[k] == EIE);
      if (k <= 3) g3_skp = g3_skp & (s[k] == G3SKP);
      g3_eios  = g3_eios & (s[k] == G3EIOS);
      g3_eieos = g3_eieos & (s[k] == (((k % 2) == 0) ? 8'h00 : 8'hFF));
    end

    // Priority order matters: the first matching rule wins.
    os_class = OS_NONE;
    if (gen < 3'd3) begin
      if (s[0] == COM) begin
        if (g1_ts1)        os_class = OS_TS1;
        else if (g1_ts2)   os_class = OS_TS2;
        else if (g1_eios)  os_class = OS_EIOS;
        else if (g1_skp)   os_class = OS_SKP;
        else if (g1_eieos) os_class = OS_EIEOS;
      end
    end else begin
      if (s[0] == G3TS1)      os_class = OS_TS1;
      else if (s[0] == G3TS2) os_class = OS_TS2;
      else if (g3_eios)       os_class = OS_EIOS;
      else if (g3_eieos)      os_class = OS_EIEOS;
      else if (g3_skp)        os_class = OS_SKP;
    end
  end

endmodule

// File: rtl/os_ts_analyzer.sv
// Classifies the lane-aligned ordered set, extracts TS fields for the LTSSM and
// counts consecutive identical training sets. One register stage of latency.
module os_ts_analyzer
  import os_pkg::*;
#(
  parameter int MAXLANES    = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              gen,
  input  logic [4:0]              numberOfDetectedLanes,
  input  logic [4:0]              substate,
  input  logic                    valid,
  input  logic [MAXLANES*128-1:0] outOs,
  output logic                    osValid,
  output logic [2:0]              osType,
  output logic                    laneMismatch,
  output logic [7:0]              linkNumber,
  output logic [MAXLANES*8-1:0]   laneNumbers,
  output logic                    linkPad,
  output logic                    lanePad,
  output logic [7:0]              nFts,
  output logic [7:0]              dataRate,
  output logic [7:0]              trainingCtrl,
  output logic [COUNT_WIDTH-1:0]  tsCount,
  output logic                    eiosSeen
);

  // valid is a one-way strobe with no ready: outOs is consumed on every clk edge
  // where valid=1, including back-to-back cycles.
  logic [MAXLANES-1:0][2:0] lane_class;
  logic [MAXLANES-1:0]      lane_active;
  logic [4:0]               n_active;
  logic                     mismatch;
  logic [2:0]               common_type;
  logic [127:0]             lane0;
  logic [KEY_W-1:0]         key;
  logic                     sub_change;

  logic                   os_valid_q, os_valid_d;
  logic [2:0]             os_type_q, os_type_d;
  logic                   lane_mismatch_q, lane_mismatch_d;
  logic [7:0]             link_number_q, link_number_d;
  logic [MAXLANES*8-1:0]  lane_numbers_q, lane_numbers_d;
  logic                   link_pad_q, link_pad_d;
  logic                   lane_pad_q, lane_pad_d;
  logic [7:0]             nfts_q, nfts_d;
  logic [7:0]             data_rate_q, data_rate_d;
  logic [7:0]             training_ctrl_q, training_ctrl_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [KEY_W-1:0]       prev_key_q, prev_key_d;
  logic [4:0]             prev_substate_q, prev_substate_d;
  logic                   eios_seen_q, eios_seen_d;

  always_comb begin
    case (numberOfDetectedLanes)
      5'd1, 5'd2, 5'd4, 5'd8, 5'd16: n_active = numberOfDetectedLanes;
      default:                       n_active = 5'd1;
    endcase
  end

  for (genvar l = 0; l < MAXLANES; l++) begin : g_lane
    os_lane_classifier u_cls (
      .gen      (gen),
      .lane     (outOs[l*128 +: 128]),
      .os_class (lane_class[l])
    );
    assign lane_active[l] = (l < int'(n_active));
  end

  always_comb begin
    mismatch = 1'b0;
    for (int l = 0; l < MAXLANES; l++) begin
      if (lane_active[l] && (lane_class[l] != lane_class[0])) mismatch = 1'b1;
    end
    common_type = mismatch ? OS_NONE : lane_class[0];
  end

  assign lane0      = outOs[127:0];
  assign key        = {common_type, lane0[15:8], lane0[23:16], lane0[31:24],
                       lane0[39:32], lane0[47:40]};
  assign sub_change = (substate != prev_substate_q);

  always_comb begin
    os_valid_d      = valid;
    os_type_d       = os_type_q;
    lane_mismatch_d = lane_mismatch_q;
    link_number_d   = link_number_q;
    lane_numbers_d  = lane_numbers_q;
    link_pad_d      = link_pad_q;
    lane_pad_d      = lane_pad_q;
    nfts_d          = nfts_q;
    data_rate_d     = data_rate_q;
    training_ctrl_d = training_ctrl_q;
    count_d         = count_q;
    prev_key_d      = prev_key_q;
    eios_seen_d     = eios_seen_q;
    prev_substate_d = substate;

    if (valid) begin
      os_type_d       = common_type;
      lane_mismatch_d = mismatch;
      link_number_d   = lane0[15:8];
      link_pad_d      = (lane0[15:8] == PAD);
      lane_pad_d      = (lane0[23:16] == PAD);
      nfts_d          = lane0[31:24];
      data_rate_d     = lane0[39:32];
      training_ctrl_d = lane0[47:40];
      for (int l = 0; l < MAXLANES; l++) begin
        lane_numbers_d[l*8 +: 8] = lane_active[l] ? outOs[l*128+16 +: 8] : 8'h00;
      end
      // SKP is transparent to the run of identical training sets.
      if (is_ts(common_type)) begin
        if (key == prev_key_q) begin
          count_d = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + 1'b1;
        end else begin
          count_d = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
        prev_key_d = key;
      end else if (common_type != OS_SKP) begin
        count_d    = '0;
        prev_key_d = '0;
      end
      if (common_type == OS_EIOS) eios_seen_d = 1'b1;
    end

    if (sub_change) begin
      count_d     = '0;
      prev_key_d  = '0;
      eios_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      os_valid_q      <= 1'b0;
      os_type_q       <= '0;
      lane_mismatch_q <= 1'b0;
      link_number_q   <= '0;
      lane_numbers_q  <= '0;
      link_pad_q      <= 1'b0;
      lane_pad_q      <= 1'b0;
      nfts_q          <= '0;
      data_rate_q     <= '0;
      training_ctrl_q <= '0;
      count_q         <= '0;
      prev_key_q      <= '0;
      prev_substate_q <= '0;
      eios_seen_q     <= 1'b0;
    end else begin
      os_valid_q      <= os_valid_d;
      os_type_q       <= os_type_d;
      lane_mismatch_q <= lane_mismatch_d;
      link_number_q   <= link_number_d;
      lane_numbers_q  <= lane_numbers_d;
      link_pad_q      <= link_pad_d;
      lane_pad_q      <= lane_pad_d;
      nfts_q          <= nfts_d;
      data_rate_q     <= data_rate_d;
      training_ctrl_q <= training_ctrl_d;
      count_q         <= count_d;
      prev_key_q      <= prev_key_d;
      prev_substate_q <= prev_substate_d;
      eios_seen_q     <= eios_seen_d;
    end
  end

  assign osValid      = os_valid_q;
  assign osType       = os_type_q;
  assign laneMismatch = lane_mismatch_q;
  assign linkNumber   = link_number_q;
  assign laneNumbers  = lane_numbers_q;
  assign linkPad      = link_pad_q;
  assign lanePad      = lane_pad_q;
  assign nFts         = nfts_q;
  assign dataRate     = data_rate_q;
  assign trainingCtrl = training_ctrl_q;
  assign tsCount      = count_q;
  assign eiosSeen     = eios_seen_q;

endmodule

// File: tb/tb_os_ts_analyzer.sv
// Directed and randomized checks of os_ts_analyzer against a behavioural model.
module tb_os_ts_analyzer;

  localparam int ML = 16;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        gen = 3'd1;
  logic [4:0]        nodl = 5'd1;
  logic [4:0]        substate = 5'd0;
  logic              valid = 1'b0;
  logic [ML*128-1:0] out_os = '0;

  logic            os_valid, lane_mismatch, link_pad, lane_pad, eios_seen;
  logic [2:0]      os_type;
  logic [7:0]      link_number, nfts, data_rate, training_ctrl;
  logic [ML*8-1:0] lane_numbers;
  logic [CW-1:0]   ts_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic            e_os_valid, e_mm, e_lpad, e_lnpad, m_eios;
  logic [2:0]      e_type;
  logic [7:0]      e_link, e_nfts, e_rate, e_ctrl;
  logic [ML*8-1:0] e_lanes;
  int              m_count;
  logic [42:0]     m_key;
  logic [4:0]      m_prev_sub;

  os_ts_analyzer #(.MAXLANES(ML), .COUNT_WIDTH(CW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .gen                   (gen),
    .numberOfDetectedLanes (nodl),
    .substate              (substate),
    .valid                 (valid),
    .outOs                 (out_os),
    .osValid               (os_valid),
    .osType                (os_type),
    .laneMismatch          (lane_mismatch),
    .linkNumber            (link_number),
    .laneNumbers           (lane_numbers),
    .linkPad               (link_pad),
    .lanePad               (lane_pad),
    .nFts                  (nfts),
    .dataRate              (data_rate),
    .trainingCtrl          (training_ctrl),
    .tsCount               (ts_count),
    .eiosSeen              (eios_seen)
  );

  // Clock / safety net
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Lane data helpers
  task automatic set_sym(input int l, input int k, input logic [7:0] v);
    out_os[l*128 + 8*k +: 8] = v;
  endtask

  function automatic logic [7:0] get_sym(input int l, input int k);
    return out_os[l*128 + 8*k +: 8];
  endfunction

  // kind: 0 random, 1 TS1, 2 TS2, 3 EIOS, 4 EIEOS, 5 SKP
  task automatic set_lane(input int l, input int kind, input logic [7:0] f1, input logic [7:0] f2,
                          input logic [7:0] f3, input logic [7:0] f4, input logic [7:0] f5);
    for (int k = 0; k < 16; k++) set_sym(l, k, 8'($urandom));
    if (gen < 3'd3) begin
      if (kind != 0) set_sym(l, 0, 8'hBC);
      case (kind)
        1, 2: begin
          set_sym(l, 1, f1); set_sym(l, 2, f2); set_sym(l, 3, f3); set_sym(l, 4, f4); set_sym(l, 5, f5);
          for (int k = 6; k < 16; k++) set_sym(l, k, (kind == 1) ? 8'h4A : 8'h45);
        end
        3: for (int k = 1; k < 4; k++) set_sym(l, k, 8'h7C);
        4: for (int k = 1; k < 15; k++) set_sym(l, k, 8'hFC);
        5: for (int k = 1; k < 4; k++) set_sym(l, k, 8'h1C);
        default: ;
      endcase
    end else begin
      case (kind)
        1, 2: begin
          set_sym(l, 0, (kind == 1) ? 8'h1E : 8'h2D);
          set_sym(l, 1, f1); set_sym(l, 2, f2); set_sym(l, 3, f3); set_sym(l, 4, f4); set_sym(l, 5, f5);
        end
        3: for (int k = 0; k < 16; k++) set_sym(l, k, 8'h66);
        4: for (int k = 0; k < 16; k++) set_sym(l, k, (k % 2 == 0) ? 8'h00 : 8'hFF);
        5: for (int k = 0; k < 4; k++) set_sym(l, k, 8'hAA);
        default: ;
      endcase
    end
  endtask

  task automatic set_all(input int kind, input logic [7:0] f1, input logic [7:0] s2_base,
                         input logic [7:0] f3, input logic [7:0] f4, input logic [7:0] f5);
    for (int l = 0; l < ML; l++) set_lane(l, kind, f1, s2_base + 8'(l), f3, f4, f5);
  endtask

  // Reference model: rules stated as symbol-range predicates
  function automatic logic all_eq(input int l, input int lo, input int hi, input logic [7:0] v);
    for (int k = lo; k <= hi; k++) if (get_sym(l, k) != v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] ref_class(input logic [2:0] g, input int l);
    logic alt;
    if (g < 3'd3) begin
      if (get_sym(l, 0) != 8'hBC) return 3'd0;
      if (all_eq(l, 6, 15, 8'h4A)) return 3'd1;
      if (all_eq(l, 6, 15, 8'h45)) return 3'd2;
      if (all_eq(l, 1, 3, 8'h7C))  return 3'd3;
      if (all_eq(l, 1, 3, 8'h1C))  return 3'd5;
      if (all_eq(l, 1, 14, 8'hFC)) return 3'd4;
      return 3'd0;
    end
    if (get_sym(l, 0) == 8'h1E) return 3'd1;
    if (get_sym(l, 0) == 8'h2D) return 3'd2;
    if (all_eq(l, 0, 15, 8'h66)) return 3'd3;
    alt = 1'b1;
    for (int k = 0; k < 16; k++) if (get_sym(l, k) != ((k % 2 == 0) ? 8'h00 : 8'hFF)) alt = 1'b0;
    if (alt) return 3'd4;
    if (all_eq(l, 0, 3, 8'hAA)) return 3'd5;
    return 3'd0;
  endfunction

  function automatic int ref_active(input logic [4:0] n);
    if (n == 1 || n == 2 || n == 4 || n == 8 || n == 16) return int'(n);
    return 1;
  endfunction

  task automatic model_edge();
    logic [2:0]  ct;
    logic        mm;
    logic [42:0] key;
    int          n;
    if (reset) begin
      e_os_valid = 0; e_type = 0; e_mm = 0; e_link = 0; e_lanes = '0; e_lpad = 0;
      e_lnpad = 0; e_nfts = 0; e_rate = 0; e_ctrl = 0; m_count = 0; m_key = '0;
      m_eios = 0; m_prev_sub = '0;
    end else begin
      if (valid) begin
        n  = ref_active(nodl);
        ct = ref_class(gen, 0);
        mm = 1'b0;
        for (int l = 1; l < n; l++) if (ref_class(gen, l) != ct) mm = 1'b1;
        if (mm) ct = 3'd0;
        e_os_valid = 1; e_type = ct; e_mm = mm;
        e_link = get_sym(0, 1); e_nfts = get_sym(0, 3); e_rate = get_sym(0, 4); e_ctrl = get_sym(0, 5);
        e_lpad  = (get_sym(0, 1) == 8'hF7);
        e_lnpad = (get_sym(0, 2) == 8'hF7);
        e_lanes = '0;
        for (int l = 0; l < n; l++) e_lanes[l*8 +: 8] = get_sym(l, 2);
        key = {ct, get_sym(0, 1), get_sym(0, 2), get_sym(0, 3), get_sym(0, 4), get_sym(0, 5)};
        if (ct == 3'd1 || ct == 3'd2) begin
          if (key == m_key) m_count = (m_count >= (1 << CW) - 1) ? (1 << CW) - 1 : m_count + 1;
          else m_count = 1;
          m_key = key;
        end else if (ct != 3'd5) begin
          m_count = 0; m_key = '0;
        end
        if (ct == 3'd3) m_eios = 1;
      end else begin
        e_os_valid = 0;
      end
      if (substate != m_prev_sub) begin
        m_count = 0; m_key = '0; m_eios = 0;
      end
      m_prev_sub = substate;
    end
  endtask

  // Scoreboard
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".osValid"},      128'(os_valid),      128'(e_os_valid));
    chk({tag, ".osType"},       128'(os_type),       128'(e_type));
    chk({tag, ".laneMismatch"}, 128'(lane_mismatch), 128'(e_mm));
    chk({tag, ".linkNumber"},   128'(link_number),   128'(e_link));
    chk({tag, ".laneNumbers"},  128'(lane_numbers),  128'(e_lanes));
    chk({tag, ".linkPad"},      128'(link_pad),      128'(e_lpad));
    chk({tag, ".lanePad"},      128'(lane_pad),      128'(e_lnpad));
    chk({tag, ".nFts"},         128'(nfts),          128'(e_nfts));
    chk({tag, ".dataRate"},     128'(data_rate),     128'(e_rate));
    chk({tag, ".trainingCtrl"}, 128'(training_ctrl), 128'(e_ctrl));
    chk({tag, ".tsCount"},      128'(ts_count),      128'(m_count));
    chk({tag, ".eiosSeen"},     128'(eios_seen),     128'(m_eios));
  endtask

  // Driver: one clock edge, model update, sample 1 ns later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic new_substate(input logic [4:0] v);
    valid = 1'b0;
    substate = v;
    tick("idle");
    chk("idle.tsCount_zero", 128'(ts_count), 128'd0);
  endtask

  int exp2 [6] = '{1, 2, 3, 3, 4, 5};
  int kind2 [6] = '{1, 1, 1, 5, 1, 1};

  initial begin
    // Reset
    reset = 1'b1;
    tick("reset0");
    tick("reset1");
    chk("reset.osValid", 128'(os_valid), 128'd0);
    chk("reset.tsCount", 128'(ts_count), 128'd0);
    chk("reset.laneNumbers", 128'(lane_numbers), 128'd0);
    reset = 1'b0;

    // Test 1: Gen1 x4, eight identical TS1
    new_substate(5'd1);
    gen = 3'd1; nodl = 5'd4; valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_all(1, 8'h00, 8'h00, 8'hFF, 8'h02, 8'h00);
      tick("t1");
      chk("t1.tsCount", 128'(ts_count), 128'(i + 1));
      chk("t1.osType", 128'(os_type), 128'd1);
      chk("t1.laneNumbers", 128'(lane_numbers), 128'h03020100);
    end

    // Test 2: Gen1 x2, TS1 x3, SKP, TS1 x2
    new_substate(5'd2);
    gen = 3'd1; nodl = 5'd2; valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_all(kind2[i], 8'h00, 8'h00, 8'hFF, 8'h02, 8'h00);
      tick("t2");
      chk("t2.tsCount", 128'(ts_count), 128'(exp2[i]));
      if (i == 3) chk("t2.osType_skp", 128'(os_type), 128'd5);
    end

    // Test 3: Gen3 x1, data rate change restarts the count
    new_substate(5'd3);
    gen = 3'd3; nodl = 5'd1; valid = 1'b1;
    set_all(1, 8'h01, 8'h00, 8'h20, 8'h02, 8'h00); tick("t3a");
    chk("t3a.tsCount", 128'(ts_count), 128'd1);
    set_all(1, 8'h01, 8'h00, 8'h20, 8'h02, 8'h00); tick("t3b");
    chk("t3b.tsCount", 128'(ts_count), 128'd2);
    set_all(1, 8'h01, 8'h00, 8'h20, 8'h03, 8'h00); tick("t3c");
    chk("t3c.tsCount", 128'(ts_count), 128'd1);
    chk("t3c.dataRate", 128'(data_rate), 128'h03);

    // Test 4: lane disagreement, then illegal lane count treated as one lane
    new_substate(5'd4);
    gen = 3'd1; nodl = 5'd4; valid = 1'b1;
    set_all(2, 8'h05, 8'h00, 8'h10, 8'h02, 8'h00);
    set_lane(3, 1, 8'h05, 8'h03, 8'h10, 8'h02, 8'h00);
    tick("t4");
    chk("t4.osType", 128'(os_type), 128'd0);
    chk("t4.laneMismatch", 128'(lane_mismatch), 128'd1);
    chk("t4.tsCount", 128'(ts_count), 128'd0);
    nodl = 5'd3;
    set_all(2, 8'hF7, 8'h10, 8'h10, 8'h02, 8'h00);
    set_lane(1, 1, 8'hF7, 8'h11, 8'h10, 8'h02, 8'h00);
    tick("t4b");
    chk("t4b.osType", 128'(os_type), 128'd2);
    chk("t4b.laneMismatch", 128'(lane_mismatch), 128'd0);
    chk("t4b.laneNumbers", 128'(lane_numbers), 128'h10);
    chk("t4b.linkPad", 128'(link_pad), 128'd1);

    // Test 5: Gen3 EIOS sets eiosSeen; substate change clears it
    new_substate(5'd10);
    gen = 3'd3; nodl = 5'd8; valid = 1'b1;
    set_all(3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tick("t5a");
    chk("t5a.osType", 128'(os_type), 128'd3);
    chk("t5a.eiosSeen", 128'(eios_seen), 128'd1);
    valid = 1'b0; substate = 5'd11;
    tick("t5b");
    chk("t5b.eiosSeen", 128'(eios_seen), 128'd0);
    chk("t5b.tsCount", 128'(ts_count), 128'd0);

    // Test 6: reset mid-run at tsCount=5
    new_substate(5'd12);
    gen = 3'd1; nodl = 5'd4; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_all(1, 8'h02, 8'h00, 8'h08, 8'h02, 8'h00);
      tick("t6");
    end
    chk("t6.tsCount5", 128'(ts_count), 128'd5);
    reset = 1'b1;
    tick("t6rst");
    chk("t6rst.osValid", 128'(os_valid), 128'd0);
    chk("t6rst.tsCount", 128'(ts_count), 128'd0);
    chk("t6rst.linkNumber", 128'(link_number), 128'd0);
    chk("t6rst.laneNumbers", 128'(lane_numbers), 128'd0);
    reset = 1'b0; valid = 1'b0;
    tick("t6idle");
    valid = 1'b1;
    set_all(1, 8'h02, 8'h00, 8'h08, 8'h02, 8'h00);
    tick("t6post");
    chk("t6post.tsCount", 128'(ts_count), 128'd1);

    // Test 7: counter saturation
    new_substate(5'd13);
    gen = 3'd2; nodl = 5'd16; valid = 1'b1;
    for (int i = 0; i < 258; i++) begin
      set_all(2, 8'h07, 8'h00, 8'h40, 8'h01, 8'h04);
      tick("t7");
    end
    chk("t7.tsCount_sat", 128'(ts_count), 128'd255);

    // Test 8: randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] lanes_tab [7];
      lanes_tab = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16, 5'd3, 5'd0};
      valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) gen = 3'($urandom_range(1, 5));
      if ($urandom_range(0, 15) == 0) nodl = lanes_tab[$urandom_range(0, 6)];
      if ($urandom_range(0, 15) == 0) substate = 5'($urandom_range(0, 31));
      set_all($urandom_range(0, 5), 8'($urandom_range(0, 1)), 8'h00, 8'hF7,
              8'($urandom_range(2, 3)), 8'h00);
      if ($urandom_range(0, 7) == 0)
        set_lane($urandom_range(0, ML - 1), $urandom_range(0, 5), 8'h00, 8'h01, 8'hF7, 8'h02, 8'h00);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
